// File: rtl/expu_accumulator.sv
// Row-sum accumulator for exponential results: converts each FP element to unsigned
// fixed point, sums it with saturation and hands the row total downstream.
module expu_accumulator #(
    // 0: FP32, 1: FP16, 2: BF16 (FPFORMAT_IN, the expu_row output format)
    parameter int unsigned FPFORMAT  = 32'd2,
    parameter int unsigned WIDTH     = (FPFORMAT == 32'd0) ? 32'd32 : 32'd16,
    parameter int          ACC_INT   = 32'sd16,
    parameter int          ACC_FRAC  = 32'sd16,
    parameter int          CNT_WIDTH = 32'sd16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          last_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [ACC_INT+ACC_FRAC-1:0]   sum_o,
    output logic [CNT_WIDTH-1:0]          count_o,
    output logic                          overflow_o
);

    function automatic int fp_exp_bits(input int unsigned fmt);
        case (fmt)
            32'd1:   return 32'sd5;
            default: return 32'sd8;
        endcase
    endfunction

    localparam int ACC_WIDTH = ACC_INT + ACC_FRAC;
    localparam int EXP_W     = fp_exp_bits(FPFORMAT);
    localparam int MAN_W     = int'(WIDTH) - 32'sd1 - EXP_W;
    localparam int BIAS      = (32'sd1 <<< (EXP_W - 32'sd1)) - 32'sd1;
    // Mantissa with hidden bit, shifted so its binary point lands on ACC_FRAC
    localparam int WW        = ACC_WIDTH + MAN_W;
    localparam int SH_W      = $clog2(ACC_WIDTH);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e                 state_r;
    logic [ACC_WIDTH-1:0]   sum_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   ovf_r;
    logic                   valid_r;
    logic                   ready_r;

    logic [EXP_W-1:0]       exp_s;
    logic [MAN_W-1:0]       man_s;
    int                     unb_s;
    logic [SH_W-1:0]        sh_s;
    logic [WW-1:0]          wide_s;
    logic [ACC_WIDTH-1:0]   conv_s;
    logic                   conv_sat_s;
    logic [ACC_WIDTH:0]     add_s;
    logic                   acc_sat_s;
    logic [ACC_WIDTH-1:0]   sum_next_s;
    logic [CNT_WIDTH-1:0]   count_next_s;
    logic                   unused_sign_s;

    assign unused_sign_s = data_i[WIDTH-1];

    // Float-to-fixed conversion of the incoming element (sign ignored, truncating)
    always_comb begin
        exp_s      = data_i[WIDTH-2 -: EXP_W];
        man_s      = data_i[MAN_W-1:0];
        unb_s      = int'(exp_s) - BIAS;
        sh_s       = '0;
        wide_s     = '0;
        conv_s     = '0;
        conv_sat_s = 1'b0;
        if (exp_s == '0) begin
            conv_s = '0;
        end else if ((&exp_s) || (unb_s >= ACC_INT)) begin
            conv_s     = '1;
            conv_sat_s = 1'b1;
        end else if (unb_s < -ACC_FRAC) begin
            conv_s = '0;
        end else begin
            sh_s   = SH_W'(unb_s + ACC_FRAC);
            wide_s = WW'({1'b1, man_s}) << sh_s;
            conv_s = wide_s[WW-1:MAN_W];
        end
    end

    // Saturating next-sum and next-count for an accepted element
    always_comb begin
        add_s     = {1'b0, sum_r} + {1'b0, conv_s};
        acc_sat_s = conv_sat_s | add_s[ACC_WIDTH];
        if (acc_sat_s) begin
            sum_next_s = '1;
        end else begin
            sum_next_s = add_s[ACC_WIDTH-1:0];
        end
        if (&count_r) begin
            count_next_s = count_r;
        end else begin
            count_next_s = count_r + CNT_WIDTH'(1'b1);
        end
    end

    // Row FSM: accumulate in ACC, present the result in DONE until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_ACC;
            sum_r   <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else if (clear_i) begin
            state_r <= ST_ACC;
            sum_r   <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (valid_i && ready_r) begin
                        sum_r   <= sum_next_s;
                        count_r <= count_next_s;
                        ovf_r   <= ovf_r | acc_sat_s;
                        if (last_i) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_r <= ST_ACC;
                        sum_r   <= '0;
                        count_r <= '0;
                        ovf_r   <= 1'b0;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_ACC;
                    sum_r   <= '0;
                    count_r <= '0;
                    ovf_r   <= 1'b0;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = ready_r;
    assign valid_o    = valid_r;
    assign sum_o      = sum_r;
    assign count_o    = count_r;
    assign overflow_o = ovf_r;

endmodule

// File: tb/tb_expu_accumulator.sv
// Self-checking bench for expu_accumulator: directed corner rows plus random BF16 rows
// with random stalls, compared against a real-arithmetic reference model.
module tb_expu_accumulator;

    localparam int    ACC_INT   = 16;
    localparam int    ACC_FRAC  = 16;
    localparam longint SUM_MAX  = 64'h0000_0000_FFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic        last_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] sum_o;
    logic [15:0] count_o;
    logic        overflow_o;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint m_sum;
    int     m_cnt;
    bit     m_ovf;

    expu_accumulator dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .last_i     (last_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sum_o      (sum_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Exact BF16 value scaled to the fixed-point grid, floor, or saturation
    function automatic longint ref_conv(input logic [15:0] d, output bit sat);
        int  e;
        int  m;
        real v;
        sat = 1'b0;
        e = int'(d[14:7]);
        m = int'(d[6:0]);
        if (e == 0) return 64'd0;
        if (e == 255) begin
            sat = 1'b1;
            return SUM_MAX;
        end
        v = (1.0 + real'(m) / 128.0) * pow2(e - 127);
        if (v >= pow2(ACC_INT)) begin
            sat = 1'b1;
            return SUM_MAX;
        end
        return longint'($floor(v * pow2(ACC_FRAC)));
    endfunction

    task automatic model_reset();
        m_sum = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_add(input logic [15:0] d);
        bit     sat;
        longint c;
        c = ref_conv(d, sat);
        if (sat) begin
            m_sum = SUM_MAX;
            m_ovf = 1'b1;
        end else begin
            m_sum = m_sum + c;
            if (m_sum > SUM_MAX) begin
                m_sum = SUM_MAX;
                m_ovf = 1'b1;
            end
        end
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Present one element, optionally after idle cycles, and wait for its handshake
    task automatic send(input logic [15:0] d, input logic l, input int max_gap);
        int guard = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk_i);
        data_i  = d;
        last_i  = l;
        valid_i = 1'b1;
        while (!ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        check("send_ready", 32'(ready_o), 32'd1);
        if (ready_o) model_add(d);
        @(negedge clk_i);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Wait for the row result, hold ready_i low for 'stall' cycles, then take it
    task automatic expect_result(input int stall);
        int guard = 0;
        while (!valid_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("valid_o", 32'(valid_o), 32'd1);
        check("sum_o", sum_o, 32'(m_sum));
        check("count_o", 32'(count_o), 32'(m_cnt));
        check("overflow_o", 32'(overflow_o), 32'(m_ovf));
        check("ready_o_done", 32'(ready_o), 32'd0);
        for (int i = 0; i < stall; i++) begin
            ready_i = 1'b0;
            @(negedge clk_i);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_sum", sum_o, 32'(m_sum));
            check("hold_count", 32'(count_o), 32'(m_cnt));
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        model_reset();
        check("post_valid", 32'(valid_o), 32'd0);
        check("post_ready", 32'(ready_o), 32'd1);
        check("post_sum", sum_o, 32'd0);
        check("post_count", 32'(count_o), 32'd0);
        check("post_ovf", 32'(overflow_o), 32'd0);
    endtask

    function automatic logic [15:0] gen_elem();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) return 16'h7F80;
        if (r < 3) return 16'h7FC1;
        if (r < 6) return {1'b0, 8'h00, 7'($urandom)};
        return {1'b0, 8'($urandom_range(100, 140)), 7'($urandom)};
    endfunction

    initial begin
        int total = 0;
        int n;
        rst_i   = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b0;
        data_i  = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_sum", sum_o, 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 1 + 0.5 + 0.25 back-to-back
        send(16'h3F80, 1'b0, 0);
        send(16'h3F00, 1'b0, 0);
        send(16'h3E80, 1'b1, 0);
        check("b2b_latency", 32'(valid_o), 32'd1);
        check("b2b_sum", sum_o, 32'h0001_C000);
        check("b2b_count", 32'(count_o), 32'd3);
        expect_result(0);

        // Single-element row held by downstream backpressure
        send(16'h3F80, 1'b1, 0);
        check("single_count", 32'(count_o), 32'd1);
        expect_result(5);

        // Infinity saturates; overflow does not leak into the next row
        send(16'h7F80, 1'b0, 0);
        send(16'h3F80, 1'b1, 0);
        check("inf_sum", sum_o, 32'hFFFF_FFFF);
        check("inf_ovf", 32'(overflow_o), 32'd1);
        check("inf_count", 32'(count_o), 32'd2);
        expect_result(1);
        send(16'h3F80, 1'b1, 0);
        check("next_row_ovf", 32'(overflow_o), 32'd0);
        expect_result(0);

        // Underflow and zero contribute nothing
        send(16'h3380, 1'b0, 0);
        send(16'h0000, 1'b1, 0);
        check("tiny_sum", sum_o, 32'd0);
        check("tiny_count", 32'(count_o), 32'd2);
        check("tiny_ovf", 32'(overflow_o), 32'd0);
        expect_result(0);

        // Reset mid-row discards the partial row
        send(16'h3F80, 1'b0, 0);
        send(16'h4000, 1'b0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_count", 32'(count_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        rst_i = 1'b0;
        model_reset();
        send(16'h3F80, 1'b1, 0);
        check("midrst_sum", sum_o, 32'h0001_0000);
        check("midrst_cnt1", 32'(count_o), 32'd1);
        expect_result(0);

        // Clear wins over an input handshake in the same cycle
        send(16'h3F80, 1'b0, 0);
        data_i  = 16'h4000;
        last_i  = 1'b1;
        valid_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        model_reset();
        check("clr_in_count", 32'(count_o), 32'd0);
        check("clr_in_sum", sum_o, 32'd0);
        check("clr_in_valid", 32'(valid_o), 32'd0);

        // Clear wins over an output handshake and empties DONE
        send(16'h4000, 1'b1, 0);
        ready_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        ready_i = 1'b0;
        model_reset();
        check("clr_out_valid", 32'(valid_o), 32'd0);
        check("clr_out_ready", 32'(ready_o), 32'd1);
        check("clr_out_sum", sum_o, 32'd0);

        // Random rows with input gaps and output stalls
        while (total < 1000) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                send(gen_elem(), (i == n - 1) ? 1'b1 : 1'b0, 2);
                total++;
            end
            expect_result($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
